// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcode constants, immediate format codes and XLEN legality check
package imm_gen_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } imm_fmt_t;

    function automatic bit xlen_ok(input int xlen);
        return xlen == 32 || xlen == 64;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_imm_decode.sv
// imm_decode: combinational RV32 immediate extraction and format classification
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm_val,
    output imm_fmt_t        imm_fmt,
    output logic            illegal
);

    logic [31:0] raw;
    logic        zext;

    // Every format is built as a 32-bit value first, then widened by sign or zero
    always_comb begin
        raw = '0;
        zext = 1'b0;
        imm_fmt = FMT_NONE;
        illegal = 1'b0;
        case (inst[6:0])
            OP_IMM: begin
                if (inst[13:12] == 2'b01) begin
                    imm_fmt = FMT_SHAMT;
                    zext = 1'b1;
                    raw = {26'b0, XLEN == 64 ? inst[25] : 1'b0, inst[24:20]};
                end else begin
                    imm_fmt = FMT_I;
                    raw = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OP_LOAD, OP_JALR: begin
                imm_fmt = FMT_I;
                raw = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                imm_fmt = FMT_S;
                raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                imm_fmt = FMT_B;
                raw = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                imm_fmt = FMT_U;
                raw = {inst[31:12], 12'b0};
            end
            OP_JAL: begin
                imm_fmt = FMT_J;
                raw = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_SYSTEM: begin
                if (inst[14]) begin
                    imm_fmt = FMT_ZIMM;
                    zext = 1'b1;
                    raw = {27'b0, inst[19:15]};
                end else begin
                    imm_fmt = FMT_I;
                    raw = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OP_OP, OP_MISC: ;
            default: illegal = 1'b1;
        endcase
        imm_val = zext ? XLEN'(raw) : XLEN'($signed(raw));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate decoder followed by a 2-entry valid/ready buffer
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_val,
    output logic [2:0]      imm_fmt,
    output logic            illegal,
    output logic [7:0]      err_cnt
);

    if (!xlen_ok(XLEN)) begin : g_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    imm_fmt_t        dec_fmt;
    logic            dec_ill;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (inst),
        .imm_val (dec_imm),
        .imm_fmt (dec_fmt),
        .illegal (dec_ill)
    );

    logic [XLEN-1:0] imm_q [2];
    logic [2:0]      fmt_q [2];
    logic [1:0]      ill_q;
    logic            wr_ptr, rd_ptr;
    logic [1:0]      count;
    logic            push, pop;

    assign in_ready  = (count != 2'd2) && rst_n;
    assign out_valid = count != 2'd0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign imm_val   = out_valid ? imm_q[rd_ptr] : '0;
    assign imm_fmt   = out_valid ? fmt_q[rd_ptr] : 3'd0;
    assign illegal   = out_valid && ill_q[rd_ptr];

    // Illegal instructions are counted as they leave, so flushed ones never count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            err_cnt <= 8'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                imm_q[wr_ptr] <= dec_imm;
                fmt_q[wr_ptr] <= dec_fmt;
                ill_q[wr_ptr] <= dec_ill;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (pop && ill_q[rd_ptr] && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule
